// File: rtl/miriscv_instr_buffer.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of {instr, pc, pc_next}.
// Optional zero-latency bypass of an empty buffer when MIRISCV_IBUF_BYPASS_EN is defined.
package miriscv_pkg;
   parameter int XLEN = 32;
   parameter int ILEN = 32;
endpackage

module miriscv_instr_buffer #(
   parameter int DEPTH = 4,
   parameter int XLEN  = miriscv_pkg::XLEN,
   parameter int ILEN  = miriscv_pkg::ILEN
) (
   input  logic                       clk_i,
   input  logic                       arstn_i,
   input  logic                       fetch_rvalid_i,
   input  logic [ILEN-1:0]            fetch_instr_i,
   input  logic [XLEN-1:0]            fetch_pc_i,
   input  logic [XLEN-1:0]            fetch_pc_next_i,
   output logic                       ibuf_stall_f_o,
   input  logic                       cu_flush_i,
   input  logic                       dec_ready_i,
   output logic                       dec_valid_o,
   output logic [ILEN-1:0]            dec_instr_o,
   output logic [XLEN-1:0]            dec_pc_o,
   output logic [XLEN-1:0]            dec_pc_next_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_next;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   entry_t          wr_entry_s;
   entry_t          head_s;
   logic            stored_s;
   logic            push_s;
   logic            pop_s;
   logic            bypass_take_s;

   // Handshake decode, output selection and next-state computation
   always_comb begin
      wr_entry_s    = '{instr: fetch_instr_i, pc: fetch_pc_i, pc_next: fetch_pc_next_i};
      head_s        = mem_q[rd_ptr_q];
      stored_s      = (count_q != {CW{1'b0}});
      bypass_take_s = 1'b0;
      dec_valid_o   = stored_s;
`ifdef MIRISCV_IBUF_BYPASS_EN
      // Empty buffer forwards the live response; if decode takes it, it is never stored
      if (!stored_s && fetch_rvalid_i && !cu_flush_i) begin
         dec_valid_o   = 1'b1;
         head_s        = wr_entry_s;
         bypass_take_s = dec_ready_i;
      end else begin
         dec_valid_o   = stored_s;
      end
`endif
      pop_s  = stored_s & dec_ready_i & ~cu_flush_i;
      push_s = fetch_rvalid_i & ~cu_flush_i & ~bypass_take_s
               & ((count_q < CW'(DEPTH)) | pop_s);

      dec_instr_o    = head_s.instr;
      dec_pc_o       = head_s.pc;
      dec_pc_next_o  = head_s.pc_next;
      count_o        = count_q;
      // Stall looks only at stored occupancy so the in-flight response always fits
      ibuf_stall_f_o = (count_q >= CW'(DEPTH - 1));

      mem_d = mem_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = wr_entry_s;
      end else begin
         mem_d = mem_q;
      end

      if (cu_flush_i) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
         rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; storage is cleared on reset so data outputs are never X
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule
